pc_branch_sequencer: RTL
========================

// Module: pc_branch_sequencer
// PURPOSE
//   Owns the program counter and sequences its next-PC mux: PC+4 or branch target, chosen by branch & alu_zero.
//   Sits between the branch/ALU-zero decision and instruction fetch.
//   Holds the PC on stall and inserts flush bubbles after a taken branch.
//   Keeps a saturating count of taken branches.
// PARAMETERS
//   XLEN          32            PC / target width
//   RESET_PC      32'h0000_0000 PC value loaded on reset
//   FLUSH_CYCLES  1             bubble cycles after a taken branch (0..7; 0 = no FLUSH state)
//   CNT_W         16            width of taken-branch counter
// PORTS
//   clk            in   1      single clock, all state updates on rising edge
//   reset          in   1      synchronous, active-high
//   stall          in   1      hold PC and all state this cycle
//   branch         in   1      current instruction is a conditional branch
//   alu_zero       in   1      ALU zero flag for current instruction
//   branch_target  in   XLEN   branch target address (PC + offset)
//   pc             out  XLEN   current fetch address
//   pc_plus4       out  XLEN   pc + 4, combinational, wraps modulo 2^XLEN
//   fetch_valid    out  1      fetched instruction at pc is valid (not a bubble)
//   flush          out  1      downstream stages must squash their instruction
//   misalign_err   out  1      one-cycle pulse: taken target had [1:0] != 0
//   taken_cnt      out  CNT_W  number of taken branches, saturating
// BEHAVIOUR
//   - Reset: pc=RESET_PC, state=RUN, flush=0, misalign_err=0, taken_cnt=0; fetch_valid=1 in the first cycle after reset.
//   - Reset mid-FLUSH aborts the flush; the next cycle is RUN with pc=RESET_PC.
//   - taken = branch & alu_zero, sampled only in RUN with stall=0.
//   - States: RUN, FLUSH. A 3-bit bubble counter bcnt is used only in FLUSH.
//   - RUN, stall=1: all registers hold; fetch_valid=0; branch/alu_zero are ignored and must be re-presented.
//   - RUN, stall=0, !taken: pc <= pc+4 (0xFFFF_FFFC wraps to 0x0000_0000).
//   - RUN, stall=0, taken:
//       pc <= {branch_target[XLEN-1:2],2'b00}.
//       taken_cnt <= taken_cnt+1, saturating at all-ones.
//       misalign_err <= |branch_target[1:0] (1-cycle pulse, registered).
//       If FLUSH_CYCLES>0: enter FLUSH with bcnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
//   - FLUSH: flush=1, fetch_valid=0, pc holds the target.
//       bcnt==0 -> RUN. Otherwise bcnt decrements.
//       stall=1 freezes bcnt and the state (flush stays 1).
//   - flush and fetch_valid are combinational from state and stall.
//   - misalign_err is registered; it is 0 in every cycle except the one following the taken branch.
//   - Latency: the taken target appears on pc 1 cycle after the branch decision.
//     fetch_valid returns FLUSH_CYCLES+1 cycles after the decision (with no stall).
// CONFIGURATION
//   PC_JUMP_EN defined:
//     Adds ports jump (in, 1) and jump_target (in, XLEN).
//     jump has priority over taken.
//     A jump is handled exactly like a taken branch (align, misalign check, flush), but does NOT increment taken_cnt.
//   PC_JUMP_EN undefined: jump ports are absent; only branch redirection exists.
// STRUCTURE
//   Package pc_seq_pkg:
//     state enum {RUN, FLUSH}.
//     localparam PC_STEP=4.
//     Default XLEN and RESET_PC constants.
//   Sub-module pc_next_sel: combinational next-PC select (pc+4 / aligned target / jump target).
//   Registers, FSM and counters stay in the top module.
// TESTING
//   - Reset, no branch, 4 cycles -> pc = 0,4,8,C; fetch_valid=1; flush=0.
//   - branch=1, alu_zero=1, target=0x40 at pc=0x8, FLUSH_CYCLES=1:
//       next pc=0x40; flush=1 for 1 cycle; then pc=0x44; taken_cnt=1.
//   - branch=1, alu_zero=0 at pc=0x10 -> pc=0x14; flush never asserted; taken_cnt unchanged.
//   - stall=1 held 3 cycles at pc=0x20 with branch taken, target=0x80:
//       pc stays 0x20; then stall=0 -> pc=0x80.
//   - Misalignment and wrap-around:
//       Taken target=0x43 -> pc=0x40; misalign_err=1 for exactly 1 cycle.
//       pc=0xFFFF_FFFC, no branch -> pc=0x0.
//   - Reset asserted during FLUSH (FLUSH_CYCLES=3) -> next cycle pc=RESET_PC, flush=0, taken_cnt=0.
//     With PC_JUMP_EN: jump and taken together -> jump_target wins; taken_cnt unchanged.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pc_seq_pkg;

    // RUN fetches normally; FLUSH issues bubbles after a redirect.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Sequential fetch advances by one 32-bit instruction word.
    localparam int PC_STEP = 4;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: pc+4, word-aligned branch target, or word-aligned jump target.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the selected value is loaded.
//
// Ports:
//   pc            current fetch address
//   branch_target branch target address (PC + offset)
//   jump/jump_target  unconditional redirect, present only with PC_JUMP_EN
//   redirect      1 = take the (jump or branch) target, 0 = sequential
//   pc_plus4      pc + 4, wraps modulo 2^XLEN
//   pc_next       selected next fetch address, target forced word-aligned
//   misaligned    selected target had nonzero low bits
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] branch_target,
`ifdef PC_JUMP_EN
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
`endif
    input  logic            redirect,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned
);

    logic [XLEN-1:0] target;

    always_comb begin
`ifdef PC_JUMP_EN
        // A jump overrides any branch presented in the same cycle.
        target = jump ? jump_target : branch_target;
`else
        target = branch_target;
`endif
        pc_plus4   = pc + XLEN'(PC_STEP);
        misaligned = |target[1:0];
        pc_next    = redirect ? {target[XLEN-1:2], 2'b00} : pc_plus4;
    end

endmodule

// File: rtl/pc_branch_sequencer.sv
// Program counter owner: advances by 4 or redirects to a taken branch target, then inserts flush bubbles.
// Latency: target visible on pc 1 cycle after the decision; fetch_valid returns FLUSH_CYCLES+1 cycles after it.
// Backpressure: stall freezes pc, FSM, bubble counter and taken_cnt; branch inputs must be re-presented.
//
// Optional feature macro: PC_JUMP_EN adds jump/jump_target (jump outranks branch, not counted).
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   stall          hold all state this cycle
//   branch, alu_zero  taken = branch & alu_zero, sampled in RUN without stall
//   branch_target  redirect address (low two bits dropped, flagged via misalign_err)
//   pc, pc_plus4   current fetch address and its sequential successor
//   fetch_valid    instruction at pc is real (RUN and not stalled)
//   flush          downstream must squash (FLUSH state)
//   misalign_err   one-cycle pulse after a redirect to a non-word-aligned target
//   taken_cnt      saturating count of taken branches
module pc_branch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(RESET_PC_DEFAULT),
    parameter int              FLUSH_CYCLES = 1,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic             alu_zero,
    input  logic [XLEN-1:0]  branch_target,
`ifdef PC_JUMP_EN
    input  logic             jump,
    input  logic [XLEN-1:0]  jump_target,
`endif
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             fetch_valid,
    output logic             flush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_cnt
);

    // Bubble counter starts at FLUSH_CYCLES-1 and the exit happens on 0,
    // so FLUSH lasts exactly FLUSH_CYCLES unstalled cycles.
    localparam logic [2:0] BCNT_INIT = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

    state_t          state;
    logic [2:0]      bcnt;
    logic            taken;
    logic            redirect;
    logic            count_it;
    logic            misaligned;
    logic [XLEN-1:0] pc_next;

    always_comb begin
        taken = branch & alu_zero;
`ifdef PC_JUMP_EN
        redirect = jump | taken;
        count_it = taken & ~jump;
`else
        redirect = taken;
        count_it = taken;
`endif
    end

    pc_next_sel #(
        .XLEN (XLEN)
    ) u_next_sel (
        .pc            (pc),
        .branch_target (branch_target),
`ifdef PC_JUMP_EN
        .jump          (jump),
        .jump_target   (jump_target),
`endif
        .redirect      (redirect),
        .pc_plus4      (pc_plus4),
        .pc_next       (pc_next),
        .misaligned    (misaligned)
    );

    assign flush       = (state == FLUSH);
    assign fetch_valid = (state == RUN) && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            state        <= RUN;
            bcnt         <= 3'd0;
            taken_cnt    <= '0;
            misalign_err <= 1'b0;
        end else begin
            // Pulse output: only a redirect accepted this cycle can raise it.
            misalign_err <= 1'b0;
            case (state)
                RUN: begin
                    if (!stall) begin
                        pc <= pc_next;
                        if (redirect) begin
                            misalign_err <= misaligned;
                            if (count_it && (taken_cnt != '1)) begin
                                taken_cnt <= taken_cnt + CNT_W'(1);
                            end
                            if (FLUSH_CYCLES > 0) begin
                                state <= FLUSH;
                                bcnt  <= BCNT_INIT;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        if (bcnt == 3'd0) begin
                            state <= RUN;
                        end else begin
                            bcnt <= bcnt - 3'd1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
